// File: rtl/hyperram_wb_arbiter.sv
// hyperram_wb_arbiter
// Two-master Wishbone arbiter in front of the HyperRAM controller slave port.
// Round-robin grant is held for whole cycles. A one-cycle idle gap is forced
// between owners. A stall watchdog turns a hung beat into a Wishbone error.
module hyperram_wb_arbiter #(
    parameter int ADR_W   = 30,
    parameter int DAT_W   = 32,
    parameter int SEL_W   = DAT_W / 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    // master 0 (video / DMA reader)
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_w,
    output logic [DAT_W-1:0] m0_dat_r,
    input  logic [SEL_W-1:0] m0_sel,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [2:0]       m0_cti,
    input  logic [1:0]       m0_bte,
    output logic             m0_ack,
    output logic             m0_err,
    // master 1 (CPU / debug bridge)
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_w,
    output logic [DAT_W-1:0] m1_dat_r,
    input  logic [SEL_W-1:0] m1_sel,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [2:0]       m1_cti,
    input  logic [1:0]       m1_bte,
    output logic             m1_ack,
    output logic             m1_err,
    // slave port towards the HyperRAM controller
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_w,
    input  logic [DAT_W-1:0] s_dat_r,
    output logic [SEL_W-1:0] s_sel,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [2:0]       s_cti,
    output logic [1:0]       s_bte,
    input  logic             s_ack,
    input  logic             s_err,
    // one-hot current owner
    output logic [1:0]       grant
);

    // Counter only has to reach TIMEOUT-1.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

    state_t            state_reg, state_next;
    logic              last_reg, last_next;
    logic [WD_W-1:0]   wdog_reg, wdog_next;

    logic granted;
    logic own1;
    logic own_cyc;
    logic own_stb;
    logic expire;

    assign granted = (state_reg == GNT0) || (state_reg == GNT1);
    assign own1    = (state_reg == GNT1);
    assign own_cyc = own1 ? m1_cyc : m0_cyc;
    assign own_stb = own1 ? m1_stb : m0_stb;
    // A simultaneous slave ack/err always beats the watchdog.
    assign expire  = (TIMEOUT > 0) && granted && own_cyc && own_stb &&
                     !s_ack && !s_err && (wdog_reg == WD_LAST);

    // State, round-robin history and watchdog registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            wdog_reg  <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            wdog_reg  <= wdog_next;
        end
    end

    // Next-state: arbitrate from IDLE/GAP, release the grant only when the owner drops cyc or times out.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE, GAP: begin
                if (m0_cyc && m1_cyc)
                    state_next = last_reg ? GNT0 : GNT1;
                else if (m0_cyc)
                    state_next = GNT0;
                else if (m1_cyc)
                    state_next = GNT1;
                else
                    state_next = IDLE;
            end
            GNT0, GNT1: begin
                if (!own_cyc || expire) begin
                    state_next = GAP;
                    last_next  = own1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Watchdog counts consecutive strobed beats still waiting for a termination.
    always_comb begin
        if (TIMEOUT == 0 || !granted || expire || s_ack || s_err || !own_cyc || !own_stb)
            wdog_next = '0;
        else
            wdog_next = wdog_reg + 1'b1;
    end

    // Slave-side mux and termination routing; the non-owner never sees ack/err.
    always_comb begin
        s_adr    = '0;
        s_dat_w  = '0;
        s_sel    = '0;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_cti    = '0;
        s_bte    = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        grant    = 2'b00;
        m0_dat_r = s_dat_r;
        m1_dat_r = s_dat_r;
        if (granted) begin
            s_adr   = own1 ? m1_adr   : m0_adr;
            s_dat_w = own1 ? m1_dat_w : m0_dat_w;
            s_sel   = own1 ? m1_sel   : m0_sel;
            s_we    = own1 ? m1_we    : m0_we;
            s_cti   = own1 ? m1_cti   : m0_cti;
            s_bte   = own1 ? m1_bte   : m0_bte;
            s_cyc   = own_cyc & ~expire;
            s_stb   = own_stb & ~expire;
            grant   = own1 ? 2'b10 : 2'b01;
            if (own1) begin
                m1_ack = s_ack;
                m1_err = s_err | expire;
            end else begin
                m0_ack = s_ack;
                m0_err = s_err | expire;
            end
        end
    end

endmodule

// File: tb/tb_hyperram_wb_arbiter.sv
// tb_hyperram_wb_arbiter
// Directed scenarios followed by randomized masters/slave. A behavioural model
// (owner / last / stall count) predicts every output each cycle.
module tb_hyperram_wb_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic [AW-1:0] m_adr   [2];
    logic [DW-1:0] m_dat_w [2];
    logic [DW-1:0] m_dat_r [2];
    logic [SW-1:0] m_sel   [2];
    logic          m_cyc   [2];
    logic          m_stb   [2];
    logic          m_we    [2];
    logic [2:0]    m_cti   [2];
    logic [1:0]    m_bte   [2];
    logic          m_ack   [2];
    logic          m_err   [2];

    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w;
    logic [DW-1:0] s_dat_r;
    logic [SW-1:0] s_sel;
    logic          s_cyc, s_stb, s_we;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic          s_ack, s_err;
    logic [1:0]    grant;

    // model state
    int owner  = -1;
    int last_m = 1;
    int stall  = 0;
    int beats  = 0;
    int rlen [2];
    int quiet  = 0;

    int n_cmp = 0;
    int n_bad = 0;

    hyperram_wb_arbiter #(.ADR_W(AW), .DAT_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_adr(m_adr[0]), .m0_dat_w(m_dat_w[0]), .m0_dat_r(m_dat_r[0]), .m0_sel(m_sel[0]),
        .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_cti(m_cti[0]),
        .m0_bte(m_bte[0]), .m0_ack(m_ack[0]), .m0_err(m_err[0]),
        .m1_adr(m_adr[1]), .m1_dat_w(m_dat_w[1]), .m1_dat_r(m_dat_r[1]), .m1_sel(m_sel[1]),
        .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_cti(m_cti[1]),
        .m1_bte(m_bte[1]), .m1_ack(m_ack[1]), .m1_err(m_err[1]),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .grant(grant)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Owner has waited TO strobed cycles without a termination.
    function automatic logic model_expire();
        if (!reset_n || owner < 0) return 1'b0;
        return m_cyc[owner] && m_stb[owner] && !s_ack && !s_err && (stall == TO - 1);
    endfunction

    task automatic compare_all();
        logic ex, oc, os;
        int o;
        o  = reset_n ? owner : -1;
        ex = model_expire();
        oc = 1'b0;
        os = 1'b0;
        if (o >= 0) begin
            oc = m_cyc[o];
            os = m_stb[o];
        end
        chk("s_cyc", 64'(s_cyc), 64'(oc && !ex));
        chk("s_stb", 64'(s_stb), 64'(os && !ex));
        chk("grant", 64'(grant), (o < 0) ? 64'd0 : ((o == 0) ? 64'd1 : 64'd2));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_ack", i), 64'(m_ack[i]), 64'((o == i) && s_ack));
            chk($sformatf("m%0d_err", i), 64'(m_err[i]), 64'((o == i) && (s_err || ex)));
        end
        if (o >= 0) begin
            chk("s_adr",   64'(s_adr),   64'(m_adr[o]));
            chk("s_dat_w", 64'(s_dat_w), 64'(m_dat_w[o]));
            chk("s_sel",   64'(s_sel),   64'(m_sel[o]));
            chk("s_we",    64'(s_we),    64'(m_we[o]));
            chk("s_cti",   64'(s_cti),   64'(m_cti[o]));
            chk("s_bte",   64'(s_bte),   64'(m_bte[o]));
            chk("m0_dat_r", 64'(m_dat_r[0]), 64'(s_dat_r));
            chk("m1_dat_r", 64'(m_dat_r[1]), 64'(s_dat_r));
        end
    endtask

    task automatic model_update();
        logic ex;
        ex = model_expire();
        if (!reset_n) begin
            owner  = -1;
            last_m = 1;
            stall  = 0;
            beats  = 0;
        end else if (owner >= 0) begin
            if (m_cyc[owner] && s_ack) beats++;
            if (ex || !m_cyc[owner]) begin
                $display("xfer m%0d beats=%0d %s t=%0t", owner, beats, ex ? "timeout" : "done", $time);
                last_m = owner;
                owner  = -1;
                stall  = 0;
                beats  = 0;
            end else if (s_ack || s_err || !m_stb[owner]) begin
                stall = 0;
            end else begin
                stall++;
            end
        end else begin
            if (m_cyc[0] && m_cyc[1]) owner = 1 - last_m;
            else if (m_cyc[0])        owner = 0;
            else if (m_cyc[1])        owner = 1;
        end
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic set_m(input int i, input logic we, input logic [AW-1:0] adr, input logic [2:0] cti);
        m_cyc[i]   = 1'b1;
        m_stb[i]   = 1'b1;
        m_we[i]    = we;
        m_adr[i]   = adr;
        m_dat_w[i] = 32'(adr) ^ 32'hA5A5_A5A5;
        m_sel[i]   = 4'hF;
        m_cti[i]   = cti;
        m_bte[i]   = 2'b00;
    endtask

    task automatic drop_m(input int i);
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'b0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            drop_m(i);
            m_we[i]    = 1'b0;
            m_adr[i]   = '0;
            m_dat_w[i] = '0;
            m_sel[i]   = '0;
            m_cti[i]   = '0;
            m_bte[i]   = '0;
        end
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_dat_r = '0;
    endtask

    initial begin
        idle_all();
        reset_n = 1'b0;
        @(negedge clock);

        // reset state
        settle();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc), 64'd0);
        advance();
        reset_n = 1'b1;
        tick();

        // single m0 read
        set_m(0, 1'b0, 30'h100, 3'b000);
        settle();
        chk("t1_latency_s_cyc", 64'(s_cyc), 64'd0);
        advance();
        s_ack = 1'b1;
        s_dat_r = 32'hDEAD_BEEF;
        settle();
        chk("t1_grant", 64'(grant), 64'd1);
        chk("t1_s_cyc", 64'(s_cyc), 64'd1);
        chk("t1_m0_ack", 64'(m_ack[0]), 64'd1);
        chk("t1_m0_dat_r", 64'(m_dat_r[0]), 64'hDEAD_BEEF);
        chk("t1_s_adr", 64'(s_adr), 64'h100);
        advance();
        drop_m(0);
        s_ack = 1'b0;
        tick();
        tick();

        // simultaneous requests after reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_m(0, 1'b0, 30'h10, 3'b000);
        set_m(1, 1'b0, 30'h20, 3'b000);
        tick();
        s_ack = 1'b1;
        settle();
        chk("t2_first_m0", 64'(grant), 64'd1);
        chk("t2_m1_no_ack", 64'(m_ack[1]), 64'd0);
        advance();
        drop_m(0);
        s_ack = 1'b0;
        tick();
        settle();
        chk("t2_gap_s_cyc", 64'(s_cyc), 64'd0);
        chk("t2_gap_grant", 64'(grant), 64'd0);
        advance();
        s_ack = 1'b1;
        settle();
        chk("t2_then_m1", 64'(grant), 64'd2);
        advance();
        drop_m(1);
        s_ack = 1'b0;
        tick();
        tick();
        set_m(0, 1'b0, 30'h11, 3'b000);
        set_m(1, 1'b0, 30'h21, 3'b000);
        tick();
        s_ack = 1'b1;
        settle();
        chk("t2_again_m0", 64'(grant), 64'd1);
        advance();
        drop_m(0);
        drop_m(1);
        s_ack = 1'b0;
        tick();
        tick();

        // m1 8-beat incrementing burst, m0 requests mid-burst
        set_m(1, 1'b0, 30'h200, 3'b010);
        tick();
        for (int b = 0; b < 8; b++) begin
            m_cti[1] = (b == 7) ? 3'b111 : 3'b010;
            m_adr[1] = 30'h200 + 30'(b);
            s_ack = 1'b1;
            s_dat_r = 32'(b) + 32'h5000;
            if (b == 2) set_m(0, 1'b0, 30'h300, 3'b000);
            settle();
            chk("t3_m1_ack", 64'(m_ack[1]), 64'd1);
            chk("t3_m0_ack", 64'(m_ack[0]), 64'd0);
            advance();
        end
        drop_m(1);
        s_ack = 1'b0;
        tick();
        settle();
        chk("t3_gap_grant", 64'(grant), 64'd0);
        advance();
        s_ack = 1'b1;
        settle();
        chk("t3_m0_after_gap", 64'(grant), 64'd1);
        advance();
        drop_m(0);
        s_ack = 1'b0;
        tick();
        tick();

        // watchdog: slave never answers m0, m1 waits
        set_m(0, 1'b1, 30'h400, 3'b000);
        tick();
        set_m(1, 1'b0, 30'h500, 3'b000);
        for (int i = 1; i <= TO; i++) begin
            settle();
            chk("t4_m0_err", 64'(m_err[0]), 64'(i == TO));
            chk("t4_s_cyc", 64'(s_cyc), 64'(i != TO));
            advance();
        end
        drop_m(0);
        settle();
        chk("t4_gap_grant", 64'(grant), 64'd0);
        advance();
        settle();
        chk("t4_m1_granted", 64'(grant), 64'd2);
        advance();

        // ack arrives on the expiry cycle: ack wins (m1 is now one cycle into its wait)
        for (int i = 2; i <= TO; i++) begin
            s_ack = (i == TO);
            settle();
            if (i == TO) begin
                chk("t5_m1_ack", 64'(m_ack[1]), 64'd1);
                chk("t5_m1_err", 64'(m_err[1]), 64'd0);
                chk("t5_s_cyc", 64'(s_cyc), 64'd1);
            end
            advance();
        end
        drop_m(1);
        s_ack = 1'b0;
        tick();
        tick();

        // async reset during an m0 write
        set_m(0, 1'b1, 30'h600, 3'b000);
        tick();
        settle();
        chk("t6_pre_s_cyc", 64'(s_cyc), 64'd1);
        advance();
        reset_n = 1'b0;
        settle();
        chk("t6_rst_s_cyc", 64'(s_cyc), 64'd0);
        chk("t6_rst_s_stb", 64'(s_stb), 64'd0);
        chk("t6_rst_grant", 64'(grant), 64'd0);
        advance();
        reset_n = 1'b1;
        set_m(1, 1'b0, 30'h700, 3'b000);
        tick();
        s_ack = 1'b1;
        settle();
        chk("t6_after_m0", 64'(grant), 64'd1);
        advance();
        idle_all();
        tick();
        tick();

        // randomized traffic
        rlen[0] = 0;
        rlen[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_cyc[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        m_cyc[i] = 1'b1;
                        rlen[i]  = int'($urandom_range(1, 30));
                    end
                end else if (rlen[i] == 0) begin
                    m_cyc[i] = 1'b0;
                end else begin
                    rlen[i]--;
                end
                m_stb[i]   = m_cyc[i] && ($urandom_range(0, 7) != 0);
                m_we[i]    = 1'($urandom_range(0, 1));
                m_adr[i]   = 30'($urandom());
                m_dat_w[i] = $urandom();
                m_sel[i]   = 4'($urandom_range(0, 15));
                m_cti[i]   = 3'($urandom_range(0, 7));
                m_bte[i]   = 2'($urandom_range(0, 3));
            end
            if (quiet > 0) begin
                quiet--;
                s_ack = 1'b0;
                s_err = 1'b0;
            end else begin
                int r;
                if ($urandom_range(0, 39) == 0) quiet = int'($urandom_range(5, 30));
                r = int'($urandom_range(0, 15));
                s_ack = (r < 8);
                s_err = (r == 8);
            end
            s_dat_r = $urandom();
            reset_n = ($urandom_range(0, 599) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
